add_seq_ctrl: RTL and testbench
===============================

Name: add_seq_ctrl

Overview:
Sequencer that computes a WIDTH-bit sum one SLICE-bit nibble per cycle through a single shared slice adder, starting from the LSB. It carries the inter-slice carry in a register. It serves as the low-area alternative to the fully parallel branch-address adder for multi-cycle address and offset calculation in the CPU. It accepts a start pulse and reports busy and done. Result, carry-out and signed overflow are registered and held until the next operation completes.

Parameters:
WIDTH, 32, operand and result width; must be a multiple of SLICE.
SLICE, 4, bits added per cycle (slice adder width).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_reset  input  1  synchronous, active-high reset.
i_start  input  1  start request; sampled only in IDLE or DONE.
i_data1  input  WIDTH  operand A; captured on an accepted start.
i_data2  input  WIDTH  operand B; captured on an accepted start.
i_ci  input  1  carry-in to slice 0; captured on an accepted start.
o_busy  output  1  high while in RUN.
o_done  output  1  one-cycle pulse when the result becomes valid.
o_sum  output  WIDTH  result; held stable between completions.
o_co  output  1  carry out of the MSB slice.
o_ovf  output  1  two's-complement overflow.

Behaviour:
- Reset: i_reset sampled high at an edge forces state IDLE. It also forces o_busy=0, o_done=0, o_sum=0, o_co=0, o_ovf=0, slice index=0 and carry register=0. Reset wins over every other event, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE. NSLICE = WIDTH/SLICE.
- IDLE: i_start=1 causes these actions at the edge:
  - capture i_data1, i_data2 and i_ci into working registers;
  - set index=0;
  - go to RUN.
  With i_start=0, stay in IDLE.
- RUN: each cycle, the slice adder adds A[idx] + B[idx] + carry. The slice sum is written into working-sum slice idx, carry is updated, and idx increments. After slice NSLICE-1 is written, go to DONE.
- RUN completion: at that same edge, o_sum, o_co and o_ovf load from the working values.
- Overflow: o_ovf = (carry into the MSB) XOR (carry out). Carry into the MSB = A[MSB] ^ B[MSB] ^ S[MSB].
- DONE: lasts exactly one cycle with o_done=1. i_start=1 here is accepted, captures new operands and goes to RUN (back-to-back). Otherwise go to IDLE.
- i_start while in RUN is ignored. No queuing; the working operands do not change.
- Latency: start sampled at edge E0. Slices are computed at edges E1..E_NSLICE. o_done is high in the cycle after E_NSLICE, i.e. 8 cycles after the start edge for the defaults. Throughput is one result per NSLICE+1 cycles.
- o_busy=1 exactly in RUN. o_busy and o_done are never high together.
- o_sum/o_co/o_ovf change only at the completion edge or on reset. They are not cleared by a new start.
- Index counter width is clog2(NSLICE). It never wraps past NSLICE-1 in RUN.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default WIDTH/SLICE, and the NSLICE derivation.
- One sub-module: add_slice, a SLICE-bit carry-look-ahead adder with ports a, b, ci, s, co. It is instantiated once inside add_seq_ctrl.
- The FSM, index counter, carry register, working registers and output registers live in add_seq_ctrl.

Test Plan:
1. A=0x0000_0004, B=0x0040_0000, ci=0, start pulse.
   -> o_busy high for 8 cycles; o_done exactly 8 cycles after the start edge; o_sum=0x0040_0004, o_co=0, o_ovf=0.
2. A=0xFFFF_FFFF, B=0x0000_0001, ci=0.
   -> o_sum=0x0000_0000, o_co=1, o_ovf=0. Carry propagates through all 8 slices.
3. A=0x7FFF_FFFF, B=0x0000_0001, ci=0.
   -> o_sum=0x8000_0000, o_co=0, o_ovf=1.
   Then A=0x8000_0000, B=0x8000_0000 -> o_sum=0, o_co=1, o_ovf=1.
4. A=0x0000_000F, B=0, ci=1 -> o_sum=0x0000_0010, o_co=0.
   Also: start asserted during RUN with A=0x1234_5678 -> ignored, result unchanged.
   Also: start held high in the DONE cycle with A=1, B=2 -> accepted; o_done again 8 cycles later with o_sum=3.
5. Start A=0x1111_1111, B=0x2222_2222, then assert i_reset for one cycle after 3 RUN slices.
   -> next cycle o_busy=0, o_done=0, o_sum=0, o_co=0, o_ovf=0, state IDLE.
   A fresh start of A=5, B=6 then yields o_sum=0xB after 8 cycles.
6. Random regression: 1000 random A/B/ci pairs with back-to-back starts.
   -> each o_sum/o_co equals the {co,sum} of the 33-bit reference addition. o_sum stays stable between o_done pulses.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the slice-serial adder sequencer: state encoding,
// default geometry and the derived slice count / index width.
package add_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_slice.sv
// SLICE-bit carry-look-ahead adder; every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module add_slice
    import add_seq_ctrl_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;

    always_comb begin
        logic term;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        term = 1'b0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            term = ci;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int k = 0; k <= i; k++) begin
                term = g[k];
                for (int j = k + 1; j <= i; j++) term = term & p[j];
                c[i+1] = c[i+1] | term;
            end
        end
        s  = p ^ c[SLICE-1:0];
        co = c[SLICE];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder: one SLICE-bit slice per cycle through a shared
// look-ahead slice adder, LSB first, with held result/carry/overflow.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic             i_ci,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_co,
    output logic             o_ovf
);

    localparam int                NSLICE   = calc_nslice(WIDTH, SLICE);
    localparam int                IDX_W    = calc_idx_w(NSLICE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSLICE - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;
    logic             accept;
    int               slice_base;

    assign accept = i_start && (state_q != ST_RUN);

    // sum_d is the working sum with the current slice merged in, so the
    // completion edge can publish the full result in the same cycle.
    always_comb begin
        slice_base = int'(idx_q) * SLICE;
        slice_a    = a_q[slice_base +: SLICE];
        slice_b    = b_q[slice_base +: SLICE];
        sum_d      = sum_q;
        sum_d[slice_base +: SLICE] = slice_s;
        ovf_d      = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1]) ^ slice_co;
    end

    add_slice #(.SLICE(SLICE)) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // NOTE: operand and working-sum registers carry no reset; their contents
    // are only observed after a start reloads them, so a reset would be dead
    // logic on a wide datapath.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            a_q <= i_data1;
            b_q <= i_data2;
        end
        if (state_q == ST_RUN) begin
            sum_q <= sum_d;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
            o_co    <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        carry_q <= i_ci;
                        idx_q   <= '0;
                        o_busy  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry_q <= slice_co;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_sum   <= sum_d;
                        o_co    <= slice_co;
                        o_ovf   <= ovf_d;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed corner cases plus a
// back-to-back random run against a plain-arithmetic reference.
module tb_add_seq_ctrl;

    localparam int W      = 32;
    localparam int S      = 4;
    localparam int NSLICE = W / S;

    logic         i_clk;
    logic         i_reset;
    logic         i_start;
    logic [W-1:0] i_data1;
    logic [W-1:0] i_data2;
    logic         i_ci;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_co;
    logic         o_ovf;

    int n_cmp = 0;
    int n_mis = 0;

    add_seq_ctrl #(.WIDTH(W), .SLICE(S)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .i_ci    (i_ci),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_co    (o_co),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT in IDLE or DONE; returns at the
    // falling edge where o_done is seen. poke_at>0 raises i_start with junk
    // operands for one clock while the operation is running.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input int poke_at);
        logic [W:0]   ref_full;
        logic         ref_ovf;
        logic [W-1:0] prev_sum;
        logic         prev_co;
        logic         prev_ovf;
        int           busy_n;
        int           done_at;
        bit           held_ok;
        bit           excl_ok;
        prev_sum = o_sum;
        prev_co  = o_co;
        prev_ovf = o_ovf;
        busy_n   = 0;
        done_at  = 0;
        held_ok  = 1'b1;
        excl_ok  = 1'b1;
        i_start  = 1'b1;
        i_data1  = a;
        i_data2  = b;
        i_ci     = ci;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        for (int k = 1; k <= 2 * NSLICE + 4 && done_at == 0; k++) begin
            @(negedge i_clk);
            if (k == poke_at) begin
                i_start = 1'b1;
                i_data1 = 32'h1234_5678;
                i_data2 = 32'h0F0F_0F0F;
            end else if (k == poke_at + 1) begin
                i_start = 1'b0;
            end
            if (o_busy && o_done) excl_ok = 1'b0;
            if (o_busy) busy_n++;
            if (o_done) done_at = k;
            else if (o_sum !== prev_sum || o_co !== prev_co || o_ovf !== prev_ovf) held_ok = 1'b0;
        end
        ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        ref_ovf  = (a[W-1] == b[W-1]) && (ref_full[W-1] != a[W-1]);
        check({tag, ".done_at"}, 64'(done_at), 64'(NSLICE + 1));
        check({tag, ".busy_n"},  64'(busy_n),  64'(NSLICE));
        check({tag, ".sum"},     64'(o_sum),   64'(ref_full[W-1:0]));
        check({tag, ".co"},      64'(o_co),    64'(ref_full[W]));
        check({tag, ".ovf"},     64'(o_ovf),   64'(ref_ovf));
        check({tag, ".held"},    64'(held_ok), 64'(1));
        check({tag, ".excl"},    64'(excl_ok), 64'(1));
    endtask

    initial begin
        bit seen;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_data1 = '0;
        i_data2 = '0;
        i_ci    = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst.busy", 64'(o_busy), 64'(0));
        check("rst.done", 64'(o_done), 64'(0));
        check("rst.sum",  64'(o_sum),  64'(0));
        check("rst.co",   64'(o_co),   64'(0));
        check("rst.ovf",  64'(o_ovf),  64'(0));
        i_reset = 1'b0;
        @(negedge i_clk);

        run_op("t1", 32'h0000_0004, 32'h0040_0000, 1'b0, 0);
        check("t1.sum_const", 64'(o_sum), 64'h0040_0004);
        @(negedge i_clk);
        check("t1.idle_done", 64'(o_done), 64'(0));
        check("t1.idle_busy", 64'(o_busy), 64'(0));

        run_op("t2",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        @(negedge i_clk);
        run_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        check("t3a.ovf_const", 64'(o_ovf), 64'(1));
        @(negedge i_clk);
        run_op("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        @(negedge i_clk);
        run_op("t4",  32'h0000_000F, 32'h0000_0000, 1'b1, 3);
        check("t4.sum_const", 64'(o_sum), 64'h0000_0010);
        run_op("t4b2b", 32'h0000_0001, 32'h0000_0002, 1'b0, 0);

        // Abort mid-run: reset after the third slice has been written.
        i_start = 1'b1;
        i_data1 = 32'h1111_1111;
        i_data2 = 32'h2222_2222;
        i_ci    = 1'b0;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("t5.busy", 64'(o_busy), 64'(0));
        check("t5.done", 64'(o_done), 64'(0));
        check("t5.sum",  64'(o_sum),  64'(0));
        check("t5.co",   64'(o_co),   64'(0));
        check("t5.ovf",  64'(o_ovf),  64'(0));
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            if (o_busy || o_done || o_sum !== '0) seen = 1'b1;
        end
        check("t5.stay_idle", 64'(seen), 64'(0));
        run_op("t5new", 32'h0000_0005, 32'h0000_0006, 1'b0, 0);
        check("t5new.sum_const", 64'(o_sum), 64'h0000_000B);

        for (int n = 0; n < 1000; n++) begin
            run_op("rnd", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
